// File: rtl/multiplicador_param.sv
// multiplicador_param: sequential shift-add multiplier, WIDTH-bit operands,
// unsigned or two's-complement, 2*WIDTH-bit product after WIDTH+1 clocks.
// Signed operands are reduced to magnitudes at acceptance and the sign is
// re-applied once in the SIGN state, so the RUN loop is purely unsigned.
module multiplicador_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 signed_op,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_SIGN,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic            neg_q, neg_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [PW-1:0]   result_q, result_d;

  // |x| as an unsigned WIDTH-bit value; the most negative value maps to 2^(WIDTH-1)
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic             is_signed);
    return (is_signed && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  // Next-state, datapath and registered-output computation
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mcand_d  = magnitude(a, signed_op);
          mplier_d = magnitude(b, signed_op);
          neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_q + (mplier_q[cnt_q] ? (PW'(mcand_q) << cnt_q) : '0);
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        result_d = neg_q ? (~acc_q + PW'(1)) : acc_q;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_SIGN);
    done_d = (state_d == S_DONE);
  end

  // Single state register for FSM, datapath and outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      neg_q    <= neg_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
